// File: rtl/mem_dump_engine_if.sv
// Memory read port and output stream of the dump engine, bundled as one interface.
// master = engine side, slave = memory/sink side.
interface mem_dump_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_LEN  = 5
);
  logic                 mem_rd_en;
  logic [ADDR_LEN-1:0]  mem_addr;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic [ADDR_LEN-1:0]  out_addr;
  logic                 out_last;
  logic                 chk_beat;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, chk_beat,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, chk_beat,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/mem_dump_engine.sv
// Reads data memory words 0..MEM_SIZE-1 and streams each one out with its address.
// Define DUMP_CHECKSUM_EN to append a trailer beat carrying the sum of all dumped words.
//   state | meaning
//   IDLE  | waiting for start
//   RD    | read strobe for word cnt
//   CAP   | memory data returned, registered into the beat
//   SEND  | beat valid, waiting for accept
//   CHK   | load checksum trailer beat (checksum build only)
//   DONE  | one-cycle completion pulse
module mem_dump_engine #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_LEN  = 5,
  parameter int MEM_SIZE  = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  mem_dump_if.master bus
);
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, SEND, DONE
`ifdef DUMP_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_LEN-1:0]  cnt, addr_q;
  logic [WORD_SIZE-1:0] data_q;
  logic                 last_q;
  logic                 accept, last_word;
`ifdef DUMP_CHECKSUM_EN
  logic [WORD_SIZE-1:0] sum_q;
  logic                 chk_q;
`endif

  assign accept    = (state == SEND) && bus.out_ready;
  assign last_word = (cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RD;
      RD:   state_nxt = CAP;
      CAP:  state_nxt = SEND;
      SEND: if (accept) begin
        if (!last_word)  state_nxt = RD;
`ifdef DUMP_CHECKSUM_EN
        else if (chk_q)  state_nxt = DONE;
        else             state_nxt = CHK;
`else
        else             state_nxt = DONE;
`endif
      end
      DONE: state_nxt = IDLE;
`ifdef DUMP_CHECKSUM_EN
      CHK:  state_nxt = SEND;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // cnt parks on the last address until DONE, so it never runs past MEM_SIZE-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      data_q <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q  <= '0;
      chk_q  <= 1'b0;
`endif
    end else begin
      case (state)
        CAP: begin
          data_q <= bus.mem_rdata;
          addr_q <= cnt;
`ifdef DUMP_CHECKSUM_EN
          last_q <= 1'b0;
          chk_q  <= 1'b0;
`else
          last_q <= last_word;
`endif
        end
        SEND: if (bus.out_ready) begin
          if (!last_word) cnt <= cnt + 1'b1;
`ifdef DUMP_CHECKSUM_EN
          if (!chk_q) sum_q <= sum_q + data_q;
`endif
        end
        DONE: begin
          cnt    <= '0;
          last_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
          chk_q  <= 1'b0;
`endif
        end
`ifdef DUMP_CHECKSUM_EN
        CHK: begin
          data_q <= sum_q;
          addr_q <= '0;
          last_q <= 1'b1;
          chk_q  <= 1'b1;
        end
        IDLE: if (start) sum_q <= '0;
`endif
        default: ;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign bus.mem_rd_en = (state == RD);
  assign bus.mem_addr  = (state == RD) ? cnt : '0;
  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_last  = last_q;
`ifdef DUMP_CHECKSUM_EN
  assign bus.chk_beat  = chk_q;
`else
  assign bus.chk_beat  = 1'b0;
`endif
endmodule

// File: tb/tb_mem_dump_engine.sv
// Scoreboard bench for mem_dump_engine: a 32-word instance and a single-word instance.
module tb_mem_dump_engine;
  localparam int W = 32;
  localparam int A = 5;
  localparam int N = 32;
  localparam int LIMIT = 3000;
`ifdef DUMP_CHECKSUM_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic [A-1:0] addr;
    logic         last;
    logic         chk;
  } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, done0, busy1, done1;

  mem_dump_if #(.WORD_SIZE(W), .ADDR_LEN(A)) bus0 ();
  mem_dump_if #(.WORD_SIZE(W), .ADDR_LEN(A)) bus1 ();

  mem_dump_engine #(.WORD_SIZE(W), .ADDR_LEN(A), .MEM_SIZE(N)) dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .busy(busy0), .done(done0), .bus(bus0)
  );
  mem_dump_engine #(.WORD_SIZE(W), .ADDR_LEN(A), .MEM_SIZE(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem0 [N];
  logic [W-1:0] mem1;

  always @(posedge clk) if (bus0.mem_rd_en) bus0.mem_rdata <= mem0[bus0.mem_addr];
  always @(posedge clk) if (bus1.mem_rd_en) bus1.mem_rdata <= mem1;

  beat_t exp0[$], exp1[$];
  int checks = 0, errors = 0;
  int beats0 = 0, dones0 = 0, beats1 = 0, dones1 = 0;
  beat_t act0, held0, e0, act1, e1;
  logic stall0 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor for the 32-word instance: pops on every accepted beat, checks stall stability.
  always @(negedge clk) begin
    if (!rstn) stall0 = 1'b0;
    else begin
      if (bus0.out_valid) begin
        act0 = '{data: bus0.out_data, addr: bus0.out_addr, last: bus0.out_last, chk: bus0.chk_beat};
        if (stall0) check("stable0", 64'(act0), 64'(held0));
        if (bus0.out_ready) begin
          if (exp0.size() == 0) check("unexpected_beat0", 64'(act0), 64'h0);
          else begin
            e0 = exp0.pop_front();
            check($sformatf("beat0_addr%0d", e0.addr), 64'(act0), 64'(e0));
          end
          beats0++;
          stall0 = 1'b0;
        end else begin
          stall0 = 1'b1;
          held0 = act0;
        end
      end else stall0 = 1'b0;
      if (done0) dones0++;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (bus1.out_valid && bus1.out_ready) begin
        act1 = '{data: bus1.out_data, addr: bus1.out_addr, last: bus1.out_last, chk: bus1.chk_beat};
        if (exp1.size() == 0) check("unexpected_beat1", 64'(act1), 64'h0);
        else begin
          e1 = exp1.pop_front();
          check("beat1", 64'(act1), 64'(e1));
        end
        beats1++;
      end
      if (done1) dones1++;
    end
  end

  task automatic push_exp0();
    for (int i = 0; i < N; i++) begin
      beat_t b;
      b.data = mem0[i];
      b.addr = A'(i);
      b.chk  = 1'b0;
      b.last = (XB == 0) && (i == N - 1);
      exp0.push_back(b);
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_valid"}, 64'(bus0.out_valid), 64'h0);
    check({tag, "_rd_en"}, 64'(bus0.mem_rd_en), 64'h0);
    check({tag, "_mem_addr"}, 64'(bus0.mem_addr), 64'h0);
    check({tag, "_data"}, 64'(bus0.out_data), 64'h0);
    check({tag, "_addr"}, 64'(bus0.out_addr), 64'h0);
    check({tag, "_last"}, 64'(bus0.out_last), 64'h0);
    check({tag, "_chk"}, 64'(bus0.chk_beat), 64'h0);
    check({tag, "_busy"}, 64'(busy0), 64'h0);
    check({tag, "_done"}, 64'(done0), 64'h0);
  endtask

  // Pulse start, then drive ready until done, stop_beat beats, or the cycle budget.
  task automatic run0(input string tag, input bit rnd, input int restart_beat,
                      input int stop_beat, input bit check_lat);
    int d0 = dones0;
    int b0 = beats0;
    int cyc = 0;
    int lat = -1;
    bit restarted = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b1;
    bus0.out_ready = 1'b1;
    while (dones0 == d0 && cyc < LIMIT && !(stop_beat >= 0 && beats0 - b0 >= stop_beat)) begin
      @(posedge clk); #1;
      cyc++;
      if (lat < 0 && bus0.out_valid) lat = cyc;
      start0 = 1'b0;
      if (restart_beat >= 0 && !restarted && beats0 - b0 == restart_beat) begin
        start0 = 1'b1;
        restarted = 1'b1;
      end
      bus0.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start0 = 1'b0;
    check({tag, "_in_budget"}, 64'(cyc < LIMIT), 64'h1);
    if (check_lat) check({tag, "_latency"}, 64'(lat), 64'd3);
    if (stop_beat < 0) begin
      check({tag, "_busy_after"}, 64'(busy0), 64'h0);
      repeat (8) @(posedge clk);
      #1;
      check({tag, "_done_count"}, 64'(dones0 - d0), 64'd1);
      check({tag, "_beat_count"}, 64'(beats0 - b0), 64'(N + XB));
      check({tag, "_queue_empty"}, 64'(exp0.size()), 64'd0);
    end
  endtask

  initial begin
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    #1 check_reset0("reset");
    check("reset1_busy", 64'(busy1), 64'h0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // 1: ascending data, ready tied high. Sum of 100..131 = 0xE70.
    for (int i = 0; i < N; i++) mem0[i] = W'(i + 100);
    push_exp0();
    if (XB == 1) exp0.push_back('{data: 32'h0000_0E70, addr: '0, last: 1'b1, chk: 1'b1});
    run0("t1", 1'b0, -1, -1, 1'b1);

    // 2: random backpressure, same sequence
    push_exp0();
    if (XB == 1) exp0.push_back('{data: 32'h0000_0E70, addr: '0, last: 1'b1, chk: 1'b1});
    run0("t2", 1'b1, -1, -1, 1'b0);

    // 3: start re-pulsed at beat 10 must be ignored
    push_exp0();
    if (XB == 1) exp0.push_back('{data: 32'h0000_0E70, addr: '0, last: 1'b1, chk: 1'b1});
    run0("t3", 1'b0, 10, -1, 1'b0);

    // 4: reset after 5 beats, then a full dump from address 0
    push_exp0();
    run0("t4a", 1'b0, -1, 5, 1'b0);
    rstn = 1'b0;
    #1 check_reset0("t4_reset");
    exp0.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    push_exp0();
    if (XB == 1) exp0.push_back('{data: 32'h0000_0E70, addr: '0, last: 1'b1, chk: 1'b1});
    run0("t4b", 1'b1, -1, -1, 1'b0);

    // 6: all-ones words; 32 * 0xFFFFFFFF mod 2^32 = 0xFFFFFFE0
    for (int i = 0; i < N; i++) mem0[i] = 32'hFFFF_FFFF;
    push_exp0();
    if (XB == 1) exp0.push_back('{data: 32'hFFFF_FFE0, addr: '0, last: 1'b1, chk: 1'b1});
    run0("t6", 1'b0, -1, -1, 1'b0);

    // 5: single-word instance
    begin
      int cyc = 0;
      mem1 = 32'hDEAD_BEEF;
      exp1.push_back('{data: 32'hDEAD_BEEF, addr: '0, last: (XB == 0), chk: 1'b0});
      if (XB == 1) exp1.push_back('{data: 32'hDEAD_BEEF, addr: '0, last: 1'b1, chk: 1'b1});
      @(posedge clk); #1;
      start1 = 1'b1;
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      while (dones1 == 0 && cyc < LIMIT) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("t5_in_budget", 64'(cyc < LIMIT), 64'h1);
      repeat (5) @(posedge clk);
      #1;
      check("t5_done_count", 64'(dones1), 64'd1);
      check("t5_beat_count", 64'(beats1), 64'(1 + XB));
      check("t5_busy_after", 64'(busy1), 64'h0);
      check("t5_queue_empty", 64'(exp1.size()), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
